// File: rtl/bfis_sched_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bfis_sched_pkg
// Description : Shared types and helpers for the bfis query scheduler:
//               FSM state encoding, query vector type and k clamping.
// Revision    : 1.0  initial release
// ============================================================================
package bfis_sched_pkg;

    // Scheduler FSM encoding; the values are visible on the debug port.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_ABORT  = 3'd3,
        S_DRAIN  = 3'd4
    } sched_state_t;

    // Default-width query vector (DIM 32-bit elements).
    localparam int QUERY_DIM = 4;
    typedef logic [QUERY_DIM-1:0][31:0] query_t;

    // Effective k: at least one result, never more than the buffer holds.
    function automatic logic [15:0] clamp_k(input logic [15:0] k, input logic [15:0] max_k);
        if (k == 16'd0) begin
            return 16'd1;
        end else if (k > max_k) begin
            return max_k;
        end else begin
            return k;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/sched_result_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sched_result_fifo
// Description : First-word-fallthrough FIFO buffering engine results until
//               they are returned on the response port. Synchronous clear,
//               active-low asynchronous reset. Pushes while full are ignored.
// Revision    : 1.0  initial release
// ============================================================================
module sched_result_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             clr_in,
    input  logic             push_in,
    input  logic [WIDTH-1:0] push_data_in,
    input  logic             pop_in,
    output logic [WIDTH-1:0] pop_data_out,
    output logic             empty_out,
    output logic             full_out,
    output logic [CNT_W-1:0] count_out
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty_out    = (cnt_q == '0);
    assign full_out     = (cnt_q == CNT_FULL);
    assign count_out    = cnt_q;
    assign pop_data_out = mem_q[rd_ptr_q];
    assign do_push      = push_in && !full_out;
    assign do_pop       = pop_in && !empty_out;

    // Next-state for storage, pointers (with non-power-of-two wrap) and count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data_in;
                wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State registers; reset wipes the contents as well as the pointers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bfis_query_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bfis_query_scheduler
// Description : Shares one bfis search engine among NUM_REQ query sources.
//               Round-robin arbitration, one query in flight, result
//               buffering, valid/ready response return and a watchdog that
//               resets a stuck engine and returns an abort marker.
// Revision    : 1.0  initial release
// ============================================================================
module bfis_query_scheduler
    import bfis_sched_pkg::*;
#(
    parameter  int          NUM_REQ        = 2,
    parameter  int          DIM            = 4,
    parameter  int          RES_DEPTH      = 8,
    parameter  int          TIMEOUT_CYCLES = 4096,
    parameter  logic [31:0] ENTRY_VERTEX   = 32'd1,
    localparam int          ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [NUM_REQ-1:0]                req_valid_in,
    output logic [NUM_REQ-1:0]                req_ready_out,
    input  logic [NUM_REQ-1:0][DIM-1:0][31:0] req_query_in,
    input  logic [NUM_REQ-1:0][15:0]          req_k_in,
    output logic                              eng_rst_out,
    output logic                              eng_valid_out,
    output logic [31:0]                       eng_vertex_id_out,
    output logic [DIM-1:0][31:0]              eng_query_out,
    output logic [15:0]                       eng_k_out,
    input  logic [31:0]                       eng_result_in,
    input  logic                              eng_result_valid_in,
    output logic                              rsp_valid_out,
    input  logic                              rsp_ready_in,
    output logic [ID_W-1:0]                   rsp_id_out,
    output logic [31:0]                       rsp_data_out,
    output logic                              rsp_last_out,
    output logic                              rsp_timeout_out,
    output logic                              busy_out,
    output logic [2:0]                        state_out,
    output logic [15:0]                       drop_cnt_out
);

    localparam int              WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int              CNT_W   = $clog2(RES_DEPTH + 1);
    localparam logic [15:0]     K_MAX   = 16'(RES_DEPTH);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);

    sched_state_t           state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]        grant_q, grant_d;
    logic [DIM-1:0][31:0]   query_q, query_d;
    logic [15:0]            k_q, k_d;
    logic [15:0]            res_cnt_q, res_cnt_d;
    logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;
    logic                   timed_out_q, timed_out_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d;

    logic                   grant_found;
    logic [ID_W-1:0]        grant_idx;
    int                     cand;

    logic                   fifo_clr;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic [31:0]            fifo_head;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [CNT_W-1:0]       fifo_count;
    logic                   is_drain;

    // Result buffer between the engine stream and the response port.
    sched_result_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .clr_in       (fifo_clr),
        .push_in      (fifo_push),
        .push_data_in (eng_result_in),
        .pop_in       (fifo_pop),
        .pop_data_out (fifo_head),
        .empty_out    (fifo_empty),
        .full_out     (fifo_full),
        .count_out    (fifo_count)
    );

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_ptr_q;
        cand        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!grant_found && req_valid_in[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Only the granted requester sees ready, and only while idle and out of reset.
    always_comb begin
        req_ready_out = '0;
        if (rst_in && (state_q == S_IDLE) && grant_found) begin
            req_ready_out[grant_idx] = 1'b1;
        end
    end

    // Scheduler FSM, watchdog, result counting and drop accounting.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        query_d     = query_q;
        k_d         = k_q;
        res_cnt_d   = res_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        timed_out_d = timed_out_q;
        drop_cnt_d  = drop_cnt_q;
        fifo_clr    = 1'b0;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    grant_d = grant_idx;
                    query_d = req_query_in[grant_idx];
                    k_d     = clamp_k(req_k_in[grant_idx], K_MAX);
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                res_cnt_d   = '0;
                wd_cnt_d    = '0;
                timed_out_d = 1'b0;
                fifo_clr    = 1'b1;
                state_d     = S_RUN;
            end
            S_RUN: begin
                wd_cnt_d = wd_cnt_q + 1'b1;
                // A result arriving on the timeout cycle is kept; completion wins.
                if (eng_result_valid_in) begin
                    fifo_push = !fifo_full;
                    res_cnt_d = res_cnt_q + 16'd1;
                    if ((res_cnt_q + 16'd1) >= k_q) begin
                        state_d = S_DRAIN;
                    end else if (wd_cnt_q == WD_LAST) begin
                        state_d = S_ABORT;
                    end
                end else if (wd_cnt_q == WD_LAST) begin
                    state_d = S_ABORT;
                end
            end
            S_ABORT: begin
                timed_out_d = 1'b1;
                state_d     = S_DRAIN;
            end
            S_DRAIN: begin
                if (rsp_ready_in) begin
                    fifo_pop = !fifo_empty;
                    if (rsp_last_out) begin
                        rr_ptr_d    = (grant_q == ID_LAST) ? '0 : grant_q + 1'b1;
                        timed_out_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Anything the engine produces outside RUN has nowhere to go.
        if (eng_result_valid_in && (state_q != S_RUN) && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Scheduler registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            query_q     <= '0;
            k_q         <= '0;
            res_cnt_q   <= '0;
            wd_cnt_q    <= '0;
            timed_out_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            query_q     <= query_d;
            k_q         <= k_d;
            res_cnt_q   <= res_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            timed_out_q <= timed_out_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign is_drain = (state_q == S_DRAIN);

    // An empty buffer in DRAIN only happens after a timeout with no results:
    // that case is a single zero-data abort beat.
    assign rsp_valid_out     = is_drain;
    assign rsp_last_out      = is_drain && (fifo_empty || (fifo_count == CNT_W'(1)));
    assign rsp_data_out      = (is_drain && !fifo_empty) ? fifo_head : 32'd0;
    assign rsp_timeout_out   = is_drain && timed_out_q;
    assign rsp_id_out        = grant_q;

    // Engine is held in reset alongside the scheduler and pulsed on abort.
    assign eng_rst_out       = !rst_in || (state_q == S_ABORT);
    assign eng_valid_out     = (state_q == S_LAUNCH);
    assign eng_vertex_id_out = ENTRY_VERTEX;
    assign eng_query_out     = query_q;
    assign eng_k_out         = k_q;

    assign busy_out          = (state_q != S_IDLE);
    assign state_out         = state_q;
    assign drop_cnt_out      = drop_cnt_q;

endmodule
`default_nettype wire
